// File: rtl/clk_div_multi_if.sv
// Rate-select and divided-clock signals of clk_div_multi.
// master drives select/enable; slave is the divider itself.
interface clk_div_multi_if #(
  parameter int unsigned SEL_W = 2
);
  logic [SEL_W-1:0] sel_in;
  logic             en_in;
  logic             clk_out;
  logic             tick_out;
  logic [SEL_W-1:0] rate_idx;

  modport master (
    output sel_in,
    output en_in,
    input  clk_out,
    input  tick_out,
    input  rate_idx
  );

  modport slave (
    input  sel_in,
    input  en_in,
    output clk_out,
    output tick_out,
    output rate_idx
  );
endinterface

// File: rtl/clk_div_multi.sv
// Switch-selectable 50%-duty clock divider: rate k = BASE_HZ << k, level and tick outputs.
// Rate changes are adopted only at half-period boundaries.
module clk_div_multi #(
  parameter int unsigned CLK_FREQ_HZ = 50000000,
  parameter int unsigned BASE_HZ     = 1,
  parameter int unsigned NUM_RATES   = 4,
  parameter int unsigned SEL_W       = 2
) (
  input  logic           clk_in,
  input  logic           rst,
  clk_div_multi_if.slave bus
);

  function automatic int unsigned hp_of(input int unsigned k);
    return CLK_FREQ_HZ / (2 * (BASE_HZ << k));
  endfunction

  localparam int unsigned HP0   = hp_of(0);
  localparam int unsigned CNT_W = (HP0 > 1) ? $clog2(HP0) : 1;

  if (hp_of(NUM_RATES - 1) < 1) begin : g_bad_hp
    $error("clk_div_multi: fastest rate has a half-period below one clock");
  end
  if ((2 ** SEL_W) < NUM_RATES) begin : g_bad_sel
    $error("clk_div_multi: SEL_W too narrow for NUM_RATES");
  end

  // Terminal count per rate, fixed at elaboration.
  logic [CNT_W-1:0] hp_last [NUM_RATES];
  for (genvar k = 0; k < NUM_RATES; k++) begin : g_hp
    assign hp_last[k] = CNT_W'(hp_of(k) - 1);
  end

  logic [SEL_W-1:0] sel_s1;
  logic [SEL_W-1:0] sel_s2;
  logic [SEL_W-1:0] sel_clamp;
  logic [CNT_W-1:0] cnt;
  logic             clk_q;
  logic             tick_q;
  logic [SEL_W-1:0] rate_q;

  always_comb begin
    sel_clamp = sel_s2;
    if (sel_s2 > SEL_W'(NUM_RATES - 1)) sel_clamp = SEL_W'(NUM_RATES - 1);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      sel_s1 <= '0;
      sel_s2 <= '0;
      cnt    <= '0;
      clk_q  <= 1'b0;
      tick_q <= 1'b0;
      rate_q <= '0;
    end else begin
      sel_s1 <= bus.sel_in;
      sel_s2 <= sel_s1;
      tick_q <= 1'b0;
      if (bus.en_in) begin
        if (cnt == hp_last[rate_q]) begin
          // New rate is latched only here, so the finished half-period ran entirely at the old rate.
          clk_q  <= ~clk_q;
          cnt    <= '0;
          rate_q <= sel_clamp;
          tick_q <= ~clk_q;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

  assign bus.clk_out  = clk_q;
  assign bus.tick_out = tick_q;
  assign bus.rate_idx = rate_q;

endmodule
